// File: rtl/hex_pkg.sv
// rtl/hex_pkg.sv - shared Q16.16 types, hex geometry constants and FSM states
package hex_pkg;

  typedef logic signed [31:0] q16_16_t;

  localparam q16_16_t SQRT3_Q16      = 32'sd113512;
  localparam q16_16_t SQRT3_DIV2_Q16 = 32'sd56756;
  localparam q16_16_t THREE_DIV2_Q16 = 32'sd98304;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2
  } state_t;

endpackage

// File: rtl/hex_fxmul.sv
// rtl/hex_fxmul.sv - signed 32x32 Q16.16 multiply, floor shift, 32-bit wrap
module hex_fxmul
  import hex_pkg::*;
(
  input  q16_16_t i_a,
  input  q16_16_t i_b,
  output q16_16_t o_p
);

  logic signed [63:0] w_full;

  assign w_full = 64'(i_a) * 64'(i_b);
  assign o_p    = q16_16_t'(w_full >>> 16);

endmodule

// File: rtl/hex_to_screen.sv
// rtl/hex_to_screen.sv - axial hex to Q16.16 screen center; HEX_CORNER_EN adds six corner beats
module hex_to_screen
  import hex_pkg::*;
#(
  parameter int COORD_W = 16
)
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COORD_W-1:0] in_q,
  input  logic signed [COORD_W-1:0] in_r,
  input  logic [31:0]               hex_size,
  input  logic signed [31:0]        origin_x,
  input  logic signed [31:0]        origin_y,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [31:0]        out_x,
  output logic signed [31:0]        out_y,
  output logic [2:0]                out_idx,
  output logic                      out_last
);

`ifdef HEX_CORNER_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd0;
`endif

  state_t r_state, w_next_state;

  logic signed [COORD_W-1:0] r_q, r_r;
  q16_16_t r_size, r_ox, r_oy, r_cx, r_cy, r_out_x, r_out_y;
  logic    r_out_valid, r_out_last;
  logic [2:0] r_out_idx;

  logic    w_in_hs, w_out_hs, w_load_first;
  q16_16_t w_q_fx, w_r_fx, w_q_term, w_rx_term, w_ry_term, w_coef_x, w_mul_x, w_mul_y;

  // Integer coordinates are promoted to Q16.16 so every product goes through hex_fxmul.
  assign w_q_fx   = q16_16_t'(r_q) <<< 16;
  assign w_r_fx   = q16_16_t'(r_r) <<< 16;
  assign w_coef_x = w_q_term + w_rx_term;

  hex_fxmul u_mul_q  (.i_a(SQRT3_Q16),      .i_b(w_q_fx),    .o_p(w_q_term));
  hex_fxmul u_mul_rx (.i_a(SQRT3_DIV2_Q16), .i_b(w_r_fx),    .o_p(w_rx_term));
  hex_fxmul u_mul_ry (.i_a(THREE_DIV2_Q16), .i_b(w_r_fx),    .o_p(w_ry_term));
  hex_fxmul u_mul_x  (.i_a(r_size),         .i_b(w_coef_x),  .o_p(w_mul_x));
  hex_fxmul u_mul_y  (.i_a(r_size),         .i_b(w_ry_term), .o_p(w_mul_y));

`ifdef HEX_CORNER_EN
  q16_16_t    r_d, w_d, w_h, w_dx, w_dy;
  logic [2:0] w_next_idx;

  hex_fxmul u_mul_d (.i_a(r_size), .i_b(SQRT3_DIV2_Q16), .o_p(w_d));

  assign w_h        = r_size >> 1;
  assign w_next_idx = r_out_idx + 3'd1;

  always_comb begin
    w_dx = '0;
    w_dy = '0;
    case (w_next_idx)
      3'd1: begin w_dx = r_d;  w_dy = -w_h;    end
      3'd2: begin w_dx = r_d;  w_dy = w_h;     end
      3'd3: begin w_dx = '0;   w_dy = r_size;  end
      3'd4: begin w_dx = -r_d; w_dy = w_h;     end
      3'd5: begin w_dx = -r_d; w_dy = -w_h;    end
      3'd6: begin w_dx = '0;   w_dy = -r_size; end
      default: begin w_dx = '0; w_dy = '0;     end
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next_state = CALC;
      CALC:    w_next_state = EMIT;
      EMIT:    if (w_out_hs && r_out_last) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // EMIT spends its first cycle loading beat 0 from the registered center.
  always_comb begin
    in_ready     = (r_state == IDLE) && !reset;
    w_in_hs      = in_valid && in_ready;
    w_out_hs     = r_out_valid && out_ready;
    w_load_first = (r_state == EMIT) && !r_out_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q         <= '0;
      r_r         <= '0;
      r_size      <= '0;
      r_ox        <= '0;
      r_oy        <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_idx   <= '0;
`ifdef HEX_CORNER_EN
      r_d         <= '0;
`endif
    end else begin
      if (w_in_hs) begin
        r_q    <= in_q;
        r_r    <= in_r;
        r_size <= hex_size;
        r_ox   <= origin_x;
        r_oy   <= origin_y;
      end
      if (r_state == CALC) begin
        r_cx <= r_ox + w_mul_x;
        r_cy <= r_oy + w_mul_y;
`ifdef HEX_CORNER_EN
        r_d  <= w_d;
`endif
      end
      if (w_load_first) begin
        r_out_valid <= 1'b1;
        r_out_x     <= r_cx;
        r_out_y     <= r_cy;
        r_out_idx   <= '0;
        r_out_last  <= (LAST_IDX == 3'd0);
      end else if (w_out_hs) begin
        if (r_out_last) r_out_valid <= 1'b0;
`ifdef HEX_CORNER_EN
        else begin
          r_out_idx  <= w_next_idx;
          r_out_x    <= r_cx + w_dx;
          r_out_y    <= r_cy + w_dy;
          r_out_last <= (w_next_idx == LAST_IDX);
        end
`endif
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;

endmodule

// File: doc/hex_to_screen.md
HEX_TO_SCREEN -- requirements
Module: hex_to_screen

Interface
REQ-001 SHALL have parameter: COORD_W, 16, signed width of axial q/r inputs.
REQ-002 SHALL have port: clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: in_valid  input  1  hex request valid; in_ready  output  1  request accepted when both high.
REQ-005 SHALL have ports: in_q, in_r  input  COORD_W  signed axial hex coordinates.
REQ-006 SHALL have ports: hex_size  input  32  unsigned Q16.16 hex radius; origin_x, origin_y  input  32  signed Q16.16 screen origin.
REQ-007 SHALL have ports: out_valid  output  1; out_ready  input  1; out_x, out_y  output  32  signed Q16.16 screen position.
REQ-008 SHALL have ports: out_idx  output  3  0=center, 1..6=corner; out_last  output  1  final beat of the current hex.

Function
REQ-009 SHALL implement pointy-top axial-to-screen conversion: x = origin_x + size*(SQRT3*q + SQRT3_DIV2*r); y = origin_y + size*(THREE_DIV2*r).
REQ-010 SHALL use constants in Q16.16: SQRT3=113512, SQRT3_DIV2=56756, THREE_DIV2=98304.
REQ-011 SHALL sign-extend q/r, form products in 64-bit signed, arithmetic-shift right 16 (floor), and wrap results to 32 bits two's complement.
REQ-012 SHALL capture in_q, in_r, hex_size, origin_x, origin_y on the input handshake; later input changes SHALL NOT affect the hex in flight.
REQ-013 SHALL use FSM states IDLE, CALC, EMIT; IDLE->CALC on handshake, CALC->EMIT after one cycle, EMIT->IDLE on the out handshake of the last beat.
REQ-014 in_ready SHALL equal (state==IDLE) and SHALL be 0 while reset is high; exactly one hex in flight.
REQ-015 For a handshake at edge k, out_valid SHALL be 1 from edge k+2, with out_idx=0 and the center coordinates.
REQ-016 While out_valid=1 and out_ready=0, out_x, out_y, out_idx, and out_last SHALL hold stable.
REQ-017 Each out handshake SHALL advance out_idx by 1 on the next edge until the beat with out_last=1 completes.
REQ-018 Corner i (out_idx=i+1, i=0..5) SHALL be the center plus offsets (+D,-H), (+D,+H), (0,+S), (-D,+H), (-D,-H), (0,-S), where S=hex_size, H=S>>1, D=(S*56756)>>16.
REQ-019 After the last beat handshake, the FSM SHALL return to IDLE; in_ready SHALL rise on the following cycle, with no same-cycle accept.

Reset
REQ-020 On reset, the block SHALL set state=IDLE, out_valid=0, out_x=0, out_y=0, out_idx=0, out_last=0, and clear all captured registers.
REQ-021 Reset asserted mid-CALC or mid-EMIT SHALL abandon the hex, set out_valid=0 at the next edge, and emit no partial beats after reset.

Configuration
REQ-022 Macro HEX_CORNER_EN SHALL select corner output.
REQ-023 With HEX_CORNER_EN defined: 7 beats per hex (idx 0..6); out_last=1 only on idx 6.
REQ-024 Without HEX_CORNER_EN: 1 beat per hex (idx 0); out_last always 1 when out_valid; no corner offset logic synthesized.

Structure
REQ-025 Package hex_pkg SHALL hold: q16_16_t typedef, SQRT3_Q16, SQRT3_DIV2_Q16, THREE_DIV2_Q16, and the FSM state enum.
REQ-026 Sub-module hex_fxmul (signed 32x32 -> Q16.16, floor shift, 32-bit wrap) SHALL be used for all products.

Verification
REQ-027 q=0, r=0, size=0x00010000, origin=(0x00640000, 0x00320000) -> beat 0 out_x=0x00640000, out_y=0x00320000, out_valid at handshake edge+2.
REQ-028 q=1, r=0, size=1.0, origin=0 -> out_x=0x0001BB68, out_y=0; q=-1 -> out_x=0xFFFE4498.
REQ-029 q=0, r=2, size=0x00020000, origin=0 -> out_x=0x000376D0, out_y=0x00060000.
REQ-030 HEX_CORNER_EN, q=r=0, size=1.0, origin=0 -> beats (0,0), (56756,-32768), (56756,32768), (0,65536), (-56756,32768), (-56756,-32768), (0,-65536); out_last only on the 7th beat.
REQ-031 out_ready low 5 cycles on beat 0 -> outputs stable, in_ready=0, new in_valid ignored; release -> sequence continues unchanged.
REQ-032 reset pulsed while out_idx=3 -> out_valid=0 next edge, in_ready=1 first cycle after reset falls, next hex starts at idx 0.
